ycbcr_mcu_aligner: RTL and testbench

- Gathers one 4:2:0 MCU: four Y blocks plus the four upsampled Cb and four upsampled Cr 8x8 blocks produced by supersample_8x8.
- Once the MCU is complete, emits aligned Y/Cb/Cr block triplets, one per handshake, to the colour-conversion stage.
- Sits directly downstream of supersample_8x8 and of the Y IDCT output path.

---
 rtl/ycbcr_mcu_aligner.sv | 108 ++++++++++
 tb/tb_ycbcr_mcu_aligner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_mcu_aligner.sv
// ycbcr_mcu_aligner: gathers a 4:2:0 MCU (4 Y, 4 Cb, 4 Cr blocks) and emits aligned Y/Cb/Cr triplets
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   y_valid, y_block, y_ready    luma block input with handshake
//   ch, chroma_valid             chroma channel tag (01 Cb, 10 Cr) and per-block valid
//   chroma_block_1..4            upsampled chroma blocks, bit k of chroma_valid qualifies block k+1
//   out_valid, out_ready         triplet output handshake
//   out_idx, y_out/cb_out/cr_out block index within the MCU and the aligned triplet
//   mcu_done                     one-cycle pulse after the last triplet of an MCU
//   overflow_err                 sticky flag set whenever chroma data is dropped
module ycbcr_mcu_aligner #(
   parameter int DATA_W  = 9,
   parameter int NUM_BLK = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            y_valid,
   input  logic [7:0][7:0][DATA_W-1:0]     y_block,
   output logic                            y_ready,
   input  logic [1:0]                      ch,
   input  logic [NUM_BLK-1:0]              chroma_valid,
   input  logic [7:0][7:0][DATA_W-1:0]     chroma_block_1,
   input  logic [7:0][7:0][DATA_W-1:0]     chroma_block_2,
   input  logic [7:0][7:0][DATA_W-1:0]     chroma_block_3,
   input  logic [7:0][7:0][DATA_W-1:0]     chroma_block_4,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [1:0]                      out_idx,
   output logic [7:0][7:0][DATA_W-1:0]     y_out,
   output logic [7:0][7:0][DATA_W-1:0]     cb_out,
   output logic [7:0][7:0][DATA_W-1:0]     cr_out,
   output logic                            mcu_done,
   output logic                            overflow_err
);
   typedef logic [7:0][7:0][DATA_W-1:0] blk_t;
   typedef enum logic {COLLECT, EMIT} state_t;
   state_t     state;
   blk_t       y_buf [4];
   blk_t       cb_buf [4];
   blk_t       cr_buf [4];
   blk_t       chroma [4];
   logic [2:0] y_cnt, y_cnt_n;
   logic [3:0] cb_mask, cr_mask, cb_wr, cr_wr;
   logic [1:0] k;
   logic       collect, y_take, drop, full;
   assign chroma = '{chroma_block_1, chroma_block_2, chroma_block_3, chroma_block_4};
   always_comb begin
      collect = state == COLLECT;
      y_ready = collect && y_cnt < 3'd4;
      y_take  = y_valid && y_ready;
      y_cnt_n = y_cnt + {2'b0, y_take};
      cb_wr   = (collect && ch == 2'b01) ? chroma_valid & ~cb_mask : 4'h0;
      cr_wr   = (collect && ch == 2'b10) ? chroma_valid & ~cr_mask : 4'h0;
      // while emitting every tagged chroma block is a drop; while collecting only repeats are
      drop    = (ch == 2'b01) ? |(chroma_valid & (collect ? cb_mask : 4'hF)) :
                (ch == 2'b10) ? |(chroma_valid & (collect ? cr_mask : 4'hF)) : 1'b0;
      full    = collect && y_cnt_n == 3'd4 && (cb_mask | cb_wr) == 4'hF && (cr_mask | cr_wr) == 4'hF;
      out_idx = k;
      // buffers are frozen during EMIT, so indexing them directly keeps the triplet stable
      y_out   = out_valid ? y_buf[k]  : '0;
      cb_out  = out_valid ? cb_buf[k] : '0;
      cr_out  = out_valid ? cr_buf[k] : '0;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state        <= COLLECT;
         y_cnt        <= 3'd0;
         cb_mask      <= 4'h0;
         cr_mask      <= 4'h0;
         k            <= 2'd0;
         out_valid    <= 1'b0;
         mcu_done     <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         mcu_done     <= 1'b0;
         overflow_err <= overflow_err | drop;
         if (collect) begin
            y_cnt   <= y_cnt_n;
            cb_mask <= cb_mask | cb_wr;
            cr_mask <= cr_mask | cr_wr;
            if (full) begin
               state     <= EMIT;
               out_valid <= 1'b1;
            end
         end else if (out_ready) begin
            if (k == 2'd3) begin
               state     <= COLLECT;
               out_valid <= 1'b0;
               k         <= 2'd0;
               y_cnt     <= 3'd0;
               cb_mask   <= 4'h0;
               cr_mask   <= 4'h0;
               mcu_done  <= 1'b1;
            end else
               k <= k + 2'd1;
         end
      end
   always_ff @(posedge clock) begin
      if (y_take)
         y_buf[y_cnt[1:0]] <= y_block;
      for (int i = 0; i < 4; i++) begin
         if (cb_wr[i])
            cb_buf[i] <= chroma[i];
         if (cr_wr[i])
            cr_buf[i] <= chroma[i];
      end
   end
endmodule

// File: tb/tb_ycbcr_mcu_aligner.sv
// tb_ycbcr_mcu_aligner: scoreboard bench for ycbcr_mcu_aligner
module tb_ycbcr_mcu_aligner;
   localparam int DW = 9;
   typedef logic [7:0][7:0][DW-1:0] blk_t;
   typedef struct {logic [1:0] idx; blk_t y, cb, cr;} trip_t;
   logic       clock, reset, y_valid, y_ready, out_valid, out_ready, mcu_done, overflow_err;
   logic [1:0] ch, out_idx;
   logic [3:0] chroma_valid;
   blk_t       y_block, chroma_block_1, chroma_block_2, chroma_block_3, chroma_block_4, y_out, cb_out, cr_out;
   int         checks = 0, errors = 0;
   trip_t      q [$];
   logic       exp_done = 1'b0;
   blk_t       ya [4], cba [4], cra [4];
   ycbcr_mcu_aligner #(.DATA_W(DW), .NUM_BLK(4)) dut (
      .clock(clock), .reset(reset), .y_valid(y_valid), .y_block(y_block), .y_ready(y_ready),
      .ch(ch), .chroma_valid(chroma_valid), .chroma_block_1(chroma_block_1), .chroma_block_2(chroma_block_2),
      .chroma_block_3(chroma_block_3), .chroma_block_4(chroma_block_4), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
      .mcu_done(mcu_done), .overflow_err(overflow_err)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   function automatic blk_t fill(input int v);
      blk_t b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r][c] = v[DW-1:0];
      return b;
   endfunction
   function automatic blk_t pat(input int a, input int b);
      blk_t o;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            o[r][c] = ((r + c) % 2 == 0) ? a[DW-1:0] : b[DW-1:0];
      return o;
   endfunction
   task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic yv, input blk_t yb, input logic [1:0] c, input logic [3:0] cv, input blk_t c0,
                      input blk_t c1, input blk_t c2, input blk_t c3);
      y_valid = yv; y_block = yb; ch = c; chroma_valid = cv;
      chroma_block_1 = c0; chroma_block_2 = c1; chroma_block_3 = c2; chroma_block_4 = c3;
      @(posedge clock); #1;
      y_valid = 1'b0; chroma_valid = 4'h0; ch = 2'b00;
   endtask
   task automatic push(input blk_t y [4], input blk_t cb [4], input blk_t cr [4]);
      trip_t t;
      for (int i = 0; i < 4; i++) begin
         t.idx = i[1:0]; t.y = y[i]; t.cb = cb[i]; t.cr = cr[i];
         q.push_back(t);
      end
   endtask
   task automatic load(input blk_t y [4], input blk_t cb [4], input blk_t cr [4]);
      cyc(1'b1, y[0], 2'b01, 4'hF, cb[0], cb[1], cb[2], cb[3]);
      cyc(1'b1, y[1], 2'b10, 4'hF, cr[0], cr[1], cr[2], cr[3]);
      cyc(1'b1, y[2], 2'b00, 4'h0, fill(0), fill(0), fill(0), fill(0));
      @(negedge clock);
      chk("early_valid", out_valid, 1'b0);
      cyc(1'b1, y[3], 2'b00, 4'h0, fill(0), fill(0), fill(0), fill(0));
   endtask
   task automatic first_out();
      @(negedge clock);
      chk("valid_latency", out_valid, 1'b1);
      chk("first_idx", out_idx, 2'd0);
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      chk("drain_timeout", q.size() == 0, 1'b1);
      @(posedge clock); #1;
   endtask
   always @(negedge clock) begin
      trip_t e;
      if (reset)
         exp_done = 1'b0;
      else begin
         chk("mcu_done", mcu_done, exp_done);
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0)
               chk("extra_triplet", 1'b1, 1'b0);
            else begin
               e = q.pop_front();
               chk("out_idx", out_idx, e.idx);
               chk("y_out", y_out, e.y);
               chk("cb_out", cb_out, e.cb);
               chk("cr_out", cr_out, e.cr);
               exp_done = e.idx == 2'd3;
            end
         end
      end
   end
   initial begin
      reset = 1'b1; out_ready = 1'b1; y_valid = 1'b0; ch = 2'b00; chroma_valid = 4'h0;
      y_block = '0; chroma_block_1 = '0; chroma_block_2 = '0; chroma_block_3 = '0; chroma_block_4 = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_y_ready", y_ready, 1'b1);
      chk("rst_mcu_done", mcu_done, 1'b0);
      chk("rst_overflow", overflow_err, 1'b0);
      chk("rst_out_idx", out_idx, 2'd0);
      chk("rst_y_out", y_out, '0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ya[i] = fill(10 * (i + 1)); cba[i] = fill(i + 1); cra[i] = fill(i + 5);
      end
      push(ya, cba, cra);
      load(ya, cba, cra);
      first_out();
      drain();
      chk("normal_overflow", overflow_err, 1'b0);
      push(ya, cba, cra);
      out_ready = 1'b0;
      load(ya, cba, cra);
      out_ready = 1'b1;
      first_out();
      @(posedge clock); #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_idx", out_idx, 2'd1);
         chk("hold_y", y_out, fill(20));
         chk("hold_cb", cb_out, fill(2));
         chk("hold_cr", cr_out, fill(6));
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      drain();
      ya = '{fill(100), fill(-100), fill(7), fill(-7)};
      cba = '{fill(11), fill(12), fill(13), fill(14)};
      cra = '{fill(21), fill(22), fill(23), fill(24)};
      push(ya, cba, cra);
      cyc(1'b1, ya[0], 2'b01, 4'b0011, cba[0], cba[1], fill(-1), fill(-1));
      cyc(1'b1, ya[1], 2'b01, 4'b1100, fill(-1), fill(-1), cba[2], cba[3]);
      cyc(1'b1, ya[2], 2'b10, 4'b0111, cra[0], cra[1], cra[2], fill(-1));
      cyc(1'b1, ya[3], 2'b00, 4'h0, fill(0), fill(0), fill(0), fill(0));
      @(negedge clock);
      chk("partial_no_emit", out_valid, 1'b0);
      chk("partial_y_ready", y_ready, 1'b0);
      cyc(1'b0, fill(0), 2'b10, 4'b1000, fill(-1), fill(-1), fill(-1), cra[3]);
      first_out();
      drain();
      chk("partial_overflow", overflow_err, 1'b0);
      ya = '{fill(1), fill(2), fill(3), fill(4)};
      cba = '{fill(-1), fill(-2), fill(-3), fill(-4)};
      cra = '{fill(50), fill(51), fill(52), fill(53)};
      push(ya, cba, cra);
      cyc(1'b1, ya[0], 2'b01, 4'hF, cba[0], cba[1], cba[2], cba[3]);
      cyc(1'b1, ya[1], 2'b01, 4'b0001, fill(-256), fill(-256), fill(-256), fill(-256));
      @(negedge clock);
      chk("dup_overflow", overflow_err, 1'b1);
      cyc(1'b1, ya[2], 2'b10, 4'hF, cra[0], cra[1], cra[2], cra[3]);
      out_ready = 1'b0;
      cyc(1'b1, ya[3], 2'b00, 4'h0, fill(0), fill(0), fill(0), fill(0));
      cyc(1'b0, fill(0), 2'b01, 4'hF, fill(-256), fill(-256), fill(-256), fill(-256));
      out_ready = 1'b1;
      @(negedge clock);
      chk("emit_overflow", overflow_err, 1'b1);
      chk("emit_y_ready", y_ready, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) begin
         ya[i] = pat(-256, 255); cba[i] = pat(255, -256); cra[i] = (i % 2 == 0) ? fill(-256) : fill(255);
      end
      ya[3] = fill(255);
      push(ya, cba, cra);
      load(ya, cba, cra);
      first_out();
      drain();
      cyc(1'b1, fill(77), 2'b01, 4'hF, fill(9), fill(9), fill(9), fill(9));
      cyc(1'b1, fill(78), 2'b00, 4'h0, fill(0), fill(0), fill(0), fill(0));
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_overflow", overflow_err, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      ya = '{fill(60), fill(61), fill(62), fill(63)};
      cba = '{fill(-60), fill(-61), fill(-62), fill(-63)};
      cra = '{fill(70), fill(71), fill(72), fill(73)};
      push(ya, cba, cra);
      load(ya, cba, cra);
      first_out();
      chk("midrst_y0", y_out, fill(60));
      drain();
      chk("final_overflow", overflow_err, 1'b0);
      chk("queue_empty", q.size() == 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
